// File: rtl/prefetch_buffer.sv
// Prefetch consumer: drops duplicate prefetches, queues survivors, fetches them and buffers returned data for demand lookup.
// Latency: request issued >=1 cycle after enqueue; demand lookup result 1 cycle after dm_v.
// Backpressure: prefetch input has none (overflow dropped with pf_drop); mem_req held stable until mem_req_rdy.
module prefetch_buffer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int QDEPTH  = 4,
  parameter int ENTRIES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      prefetch_v,
  input  logic [ADDR_W-1:0]         prefetch_addr,
  output logic                      pf_drop,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      mem_req_v,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_req_rdy,
  input  logic                      mem_resp_v,
  input  logic [DATA_W-1:0]         mem_resp_data,
  input  logic                      dm_v,
  input  logic [ADDR_W-1:0]         dm_addr,
  output logic                      dm_resp_v,
  output logic                      dm_hit,
  output logic [DATA_W-1:0]         dm_data
);

  localparam int QW = $clog2(QDEPTH);
  localparam int EW = $clog2(ENTRIES);
  localparam logic [QW:0] QFULL = (QW+1)'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fifo_q [QDEPTH];
  logic [QW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [QW:0]         count_q;
  logic [ADDR_W-1:0]   inflight_q;
  logic [ENTRIES-1:0]  buf_v_q;
  logic [ADDR_W-1:0]   buf_addr_q [ENTRIES];
  logic [DATA_W-1:0]   buf_data_q [ENTRIES];
  logic [EW-1:0]       rep_ptr_q;
  logic                pf_drop_q, dm_resp_v_q, dm_hit_q;
  logic [DATA_W-1:0]   dm_data_q;

  logic [QW-1:0]       q_off [QDEPTH];
  logic                dup, push, drop, pop, fill;
  logic                lk_hit;
  logic [DATA_W-1:0]   lk_data;

  // Duplicate check against queued, in-flight and buffered addresses (start-of-cycle state).
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      q_off[i] = QW'(i) - rd_ptr_q;
      if (({1'b0, q_off[i]} < count_q) && (fifo_q[i] == prefetch_addr)) dup = 1'b1;
    end
    for (int e = 0; e < ENTRIES; e++) begin
      if (buf_v_q[e] && (buf_addr_q[e] == prefetch_addr)) dup = 1'b1;
    end
    if ((state_q != S_IDLE) && (inflight_q == prefetch_addr)) dup = 1'b1;
  end

  // A same-cycle pop never makes room for the push: fullness is judged on the old count.
  assign push = prefetch_v && !dup && (count_q != QFULL);
  assign drop = prefetch_v && !dup && (count_q == QFULL);

  // Request sequencer: pop in IDLE, present in REQ, collect the single response in WAIT.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fill    = 1'b0;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        pop     = 1'b1;
        state_d = S_REQ;
      end
      S_REQ:  if (mem_req_rdy) state_d = S_WAIT;
      S_WAIT: if (mem_resp_v) begin
        fill    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FIFO pointers, occupancy and in-flight address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + QW'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + QW'(1);
        inflight_q <= fifo_q[rd_ptr_q];
      end
      if (push && !pop)      count_q <= count_q + (QW+1)'(1);
      else if (!push && pop) count_q <= count_q - (QW+1)'(1);
    end
  end

  // FIFO storage; validity is derived from pointers so the data needs no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= prefetch_addr;
  end

  // Buffer valid bits and round-robin replacement pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v_q   <= '0;
      rep_ptr_q <= '0;
    end else if (fill) begin
      buf_v_q[rep_ptr_q] <= 1'b1;
      rep_ptr_q          <= rep_ptr_q + EW'(1);
    end
  end

  // Buffer address/data payload, qualified by buf_v_q.
  always_ff @(posedge clk) begin
    if (fill) begin
      buf_addr_q[rep_ptr_q] <= inflight_q;
      buf_data_q[rep_ptr_q] <= mem_resp_data;
    end
  end

  // Demand probe of the buffer; addresses are unique so at most one entry matches.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (buf_v_q[e] && (buf_addr_q[e] == dm_addr)) begin
        lk_hit  = 1'b1;
        lk_data = buf_data_q[e];
      end
    end
  end

  // Registered lookup result and drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_drop_q   <= 1'b0;
      dm_resp_v_q <= 1'b0;
      dm_hit_q    <= 1'b0;
      dm_data_q   <= '0;
    end else begin
      pf_drop_q   <= drop;
      dm_resp_v_q <= dm_v;
      dm_hit_q    <= dm_v && lk_hit;
      dm_data_q   <= (dm_v && lk_hit) ? lk_data : '0;
    end
  end

  assign pf_drop      = pf_drop_q;
  assign q_count      = count_q;
  assign mem_req_v    = (state_q == S_REQ);
  assign mem_req_addr = (state_q == S_REQ) ? inflight_q : '0;
  assign dm_resp_v    = dm_resp_v_q;
  assign dm_hit       = dm_hit_q;
  assign dm_data      = dm_data_q;

endmodule
